// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: EX-stage issue/writeback control for the shift-add multiplier.
// Optional one-entry result cache enabled by defining MUL_PAIR_CACHE_EN.
module mul_issue_ctrl #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [OP_W-1:0]   mul_op,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              flush,
    output logic              ex_stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              mul_valid,
    output logic [1:0]        mul_signed,
    output logic              mulw,
    output logic [DATA_W-1:0] mul1,
    output logic [DATA_W-1:0] mul2,
    input  logic              mul_ready,
    input  logic              out_valid_m,
    input  logic [DATA_W-1:0] result_h,
    input  logic [DATA_W-1:0] result_l
);

    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MULW   = OP_W'(4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_RESP
    } state_t;

    state_t            st;
    logic [OP_W-1:0]   op_q;
    logic [1:0]        dec_signed;
    logic              dec_mulw;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    // Pick the half the op architecturally returns; MULW sign-extends bit 31.
    function automatic logic [DATA_W-1:0] sel_result(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo
    );
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: sel_result = hi;
            OP_MULW: sel_result = {{(DATA_W-32){lo[31]}}, lo[31:0]};
            default: sel_result = lo;
        endcase
    endfunction

    // Decode the incoming op into multiplier mode; reserved ops act as MUL.
    always_comb begin
        dec_signed = 2'b00;
        dec_mulw   = 1'b0;
        case (mul_op)
            OP_MULH:   dec_signed = 2'b11;
            OP_MULHSU: dec_signed = 2'b10;
            OP_MULW:   dec_mulw   = 1'b1;
            default:   ;
        endcase
    end

`ifdef MUL_PAIR_CACHE_EN
    logic              c_valid;
    logic [DATA_W-1:0] c_src1;
    logic [DATA_W-1:0] c_src2;
    logic [1:0]        c_signed;
    logic              c_mulw;
    logic [DATA_W-1:0] c_h;
    logic [DATA_W-1:0] c_l;
    logic              low_op;

    // Low-half ops do not depend on operand signedness, so they may reuse
    // a product computed under any signed mode.
    always_comb begin
        low_op   = !(mul_op == OP_MULH || mul_op == OP_MULHSU ||
                     mul_op == OP_MULHU);
        hit      = c_valid && (src1 == c_src1) && (src2 == c_src2) &&
                   (dec_mulw == c_mulw) &&
                   ((dec_signed == c_signed) || low_op);
        hit_data = sel_result(mul_op, c_h, c_l);
    end

    // Remember the last completed, non-flushed product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_valid  <= 1'b0;
            c_src1   <= '0;
            c_src2   <= '0;
            c_signed <= 2'b00;
            c_mulw   <= 1'b0;
            c_h      <= '0;
            c_l      <= '0;
        end else if (st == ST_WAIT && out_valid_m && !flush) begin
            c_valid  <= 1'b1;
            c_src1   <= mul1;
            c_src2   <= mul2;
            c_signed <= mul_signed;
            c_mulw   <= mulw;
            c_h      <= result_h;
            c_l      <= result_l;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // Issue FSM plus the registered operand, mode and result state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            op_q       <= '0;
            mul1       <= '0;
            mul2       <= '0;
            mul_signed <= 2'b00;
            mulw       <= 1'b0;
            wb_data    <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (ex_valid && !flush) begin
                        op_q       <= mul_op;
                        mul1       <= src1;
                        mul2       <= src2;
                        mul_signed <= dec_signed;
                        mulw       <= dec_mulw;
                        if (hit) begin
                            wb_data <= hit_data;
                            st      <= ST_RESP;
                        end else begin
                            st <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush)          st <= ST_IDLE;
                    else if (mul_ready) st <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (out_valid_m) begin
                        if (flush) begin
                            st <= ST_IDLE;
                        end else begin
                            wb_data <= sel_result(op_q, result_h, result_l);
                            st      <= ST_RESP;
                        end
                    end else if (flush) begin
                        st <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_m) st <= ST_IDLE;
                end
                ST_RESP: st <= ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs react to flush in the same cycle; stall is held
    // low while reset is asserted so every output reads zero.
    always_comb begin
        mul_valid = (st == ST_REQ) && !flush;
        wb_valid  = (st == ST_RESP) && !flush;
        ex_stall  = !reset &&
                    (((st == ST_IDLE) && ex_valid && !flush) ||
                     (st == ST_REQ) || (st == ST_WAIT));
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: directed vectors against a behavioural multiplier.
// Cache expectations follow MUL_PAIR_CACHE_EN when it is defined.
module tb_mul_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [2:0]  mul_op;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        ex_stall;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic        mul_valid;
    logic [1:0]  mul_signed;
    logic        mulw;
    logic [63:0] mul1;
    logic [63:0] mul2;
    logic        mul_ready;
    logic        out_valid_m;
    logic [63:0] result_h;
    logic [63:0] result_l;

    int checks;
    int failures;

    mul_issue_ctrl dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .mul_op(mul_op),
        .src1(src1), .src2(src2), .flush(flush), .ex_stall(ex_stall),
        .wb_valid(wb_valid), .wb_data(wb_data), .mul_valid(mul_valid),
        .mul_signed(mul_signed), .mulw(mulw), .mul1(mul1), .mul2(mul2),
        .mul_ready(mul_ready), .out_valid_m(out_valid_m),
        .result_h(result_h), .result_l(result_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: accepts when idle, answers 3 cycles later.
    logic       m_busy;
    logic [1:0] m_cnt;
    int         acc_cnt;

    function automatic logic [127:0] prod(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [1:0] sg);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    assign mul_ready = ~m_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy      <= 1'b0;
            m_cnt       <= 2'd0;
            out_valid_m <= 1'b0;
            result_h    <= '0;
            result_l    <= '0;
            acc_cnt     <= 0;
        end else begin
            out_valid_m <= 1'b0;
            if (!m_busy) begin
                if (mul_valid) begin
                    m_busy <= 1'b1;
                    m_cnt  <= 2'd3;
                    {result_h, result_l} <= prod(mul1, mul2, mul_signed);
                    acc_cnt <= acc_cnt + 1;
                end
            end else if (m_cnt > 2'd1) begin
                m_cnt <= m_cnt - 2'd1;
            end else if (m_cnt == 2'd1) begin
                out_valid_m <= 1'b1;
                m_cnt       <= 2'd0;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  sg;
        logic        w;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE through the multiplier and check writeback.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [1:0] sg,
                          input logic w, input logic [63:0] exp,
                          input string nm);
        int  acc0;
        bit  got;
        bit  ov_prev;
        acc0     = acc_cnt;
        ex_valid = 1'b1;
        mul_op   = op;
        src1     = a;
        src2     = b;
        #1;
        chk({nm, ".stall_idle"}, 64'(ex_stall), 64'd1);
        chk({nm, ".mv_idle"}, 64'(mul_valid), 64'd0);
        step();
        chk({nm, ".mul_valid"}, 64'(mul_valid), 64'd1);
        chk({nm, ".mul_signed"}, 64'(mul_signed), 64'(sg));
        chk({nm, ".mulw"}, 64'(mulw), 64'(w));
        chk({nm, ".mul1"}, mul1, a);
        chk({nm, ".mul2"}, mul2, b);
        got     = 1'b0;
        ov_prev = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            ov_prev = out_valid_m;
            step();
            if (wb_valid) got = 1'b1;
            else chk({nm, ".stall_busy"}, 64'(ex_stall), 64'd1);
        end
        chk({nm, ".wb_seen"}, 64'(got), 64'd1);
        chk({nm, ".wb_data"}, wb_data, exp);
        chk({nm, ".wb_lat"}, 64'(ov_prev), 64'd1);
        chk({nm, ".stall_resp"}, 64'(ex_stall), 64'd0);
        chk({nm, ".accepts"}, 64'(acc_cnt - acc0), 64'd1);
        ex_valid = 1'b0;
        step();
        chk({nm, ".wb_pulse"}, 64'(wb_valid), 64'd0);
    endtask

    initial begin
        int acc0;
        bit seen;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ex_valid = 1'b0;
        mul_op   = 3'd0;
        src1     = '0;
        src2     = '0;
        flush    = 1'b0;

        vecs[0] = '{3'd0, 64'd3, 64'd5, 2'b00, 1'b0, 64'd15, "mul"};
        vecs[1] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    2'b11, 1'b0, 64'd0, "mulh"};
        vecs[2] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu"};
        vecs[3] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                    2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu"};
        vecs[4] = '{3'd4, 64'h7FFF_FFFF, 64'd2,
                    2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "mulw_neg"};
        vecs[5] = '{3'd4, 64'h1_0000_0003, 64'd5,
                    2'b00, 1'b1, 64'd15, "mulw_low"};
        vecs[6] = '{3'd5, 64'd6, 64'd7, 2'b00, 1'b0, 64'd42, "reserved"};

        repeat (3) step();
        chk("rst.wb_valid", 64'(wb_valid), 64'd0);
        chk("rst.wb_data", wb_data, 64'd0);
        chk("rst.mul_valid", 64'(mul_valid), 64'd0);
        chk("rst.ex_stall", 64'(ex_stall), 64'd0);
        chk("rst.mul1", mul1, 64'd0);
        chk("rst.sg_w", 64'({mul_signed, mulw}), 64'd0);
        #2;
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sg,
                   vecs[i].w, vecs[i].exp, vecs[i].nm);

        // Flush in REQ while the multiplier is ready: nothing issues.
        acc0     = acc_cnt;
        ex_valid = 1'b1;
        mul_op   = 3'd0;
        src1     = 64'd9;
        src2     = 64'd9;
        step();
        flush = 1'b1;
        #1;
        chk("freq.ready", 64'(mul_ready), 64'd1);
        chk("freq.mul_valid", 64'(mul_valid), 64'd0);
        chk("freq.stall", 64'(ex_stall), 64'd1);
        step();
        flush    = 1'b0;
        ex_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("freq.no_wb", 64'(wb_valid), 64'd0);
            chk("freq.no_mv", 64'(mul_valid), 64'd0);
        end
        chk("freq.accepts", 64'(acc_cnt - acc0), 64'd0);

        // Flush mid-WAIT: drain the stale result, then a fresh 2*2.
        ex_valid = 1'b1;
        mul_op   = 3'd0;
        src1     = 64'd11;
        src2     = 64'd13;
        step();
        step();
        flush    = 1'b1;
        ex_valid = 1'b0;
        #1;
        chk("fwait.stall", 64'(ex_stall), 64'd1);
        step();
        flush    = 1'b0;
        ex_valid = 1'b1;
        src1     = 64'd2;
        src2     = 64'd2;
        #1;
        chk("drain.stall", 64'(ex_stall), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            chk("drain.no_wb", 64'(wb_valid), 64'd0);
            chk("drain.no_mv", 64'(mul_valid), 64'd0);
            if (out_valid_m) seen = 1'b1;
            else step();
        end
        chk("drain.stale_ov", 64'(seen), 64'd1);
        step();
        run_op(3'd0, 64'd2, 64'd2, 2'b00, 1'b0, 64'd4, "after_drain");

        // Asynchronous reset while waiting on the multiplier.
        ex_valid = 1'b1;
        mul_op   = 3'd1;
        src1     = 64'd100;
        src2     = 64'd100;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst.wb_data", wb_data, 64'd0);
        chk("arst.stall", 64'(ex_stall), 64'd0);
        chk("arst.mul_valid", 64'(mul_valid), 64'd0);
        chk("arst.mul1", mul1, 64'd0);
        chk("arst.mul2", mul2, 64'd0);
        chk("arst.sg_w", 64'({mul_signed, mulw}), 64'd0);
        ex_valid = 1'b0;
        step();
        step();
        #2;
        reset = 1'b0;
        step();
        run_op(3'd0, 64'd7, 64'd6, 2'b00, 1'b0, 64'd42, "after_rst");

        // MULH then MUL on the same operands.
        run_op(3'd1, 64'h1_0000_0000, 64'h1_0000_0000, 2'b11, 1'b0,
               64'd1, "pair_mulh");
`ifdef MUL_PAIR_CACHE_EN
        acc0     = acc_cnt;
        ex_valid = 1'b1;
        mul_op   = 3'd0;
        #1;
        chk("pair.stall", 64'(ex_stall), 64'd1);
        step();
        chk("pair.wb_valid", 64'(wb_valid), 64'd1);
        chk("pair.wb_data", wb_data, 64'd0);
        chk("pair.no_mv", 64'(mul_valid), 64'd0);
        ex_valid = 1'b0;
        step();
        chk("pair.wb_pulse", 64'(wb_valid), 64'd0);
        chk("pair.accepts", 64'(acc_cnt - acc0), 64'd0);
`else
        run_op(3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 2'b00, 1'b0,
               64'd0, "pair_mul");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
